// File: rtl/reg_wr_arbiter_pkg.sv
// Shared types for the register-bank write arbiter: index width helper,
// write-entry layout and grant encoding.
package reg_wr_arbiter_pkg;

  function automatic int reg_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_APB  = 2'd1,
    GNT_ACC  = 2'd2
  } gnt_e;

  localparam int DEF_REG_NUM = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_AW      = reg_aw(DEF_REG_NUM);

  // Entry layout for the default bank geometry; FIFO words are packed {addr, data}.
  typedef struct packed {
    logic [DEF_AW-1:0]     addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Synchronous FIFO for buffered accelerator writes; head is visible
// combinationally and full is a registered flag.
module reg_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;

  assign head       = mem[rd_ptr];
  assign empty      = (level == '0);
  assign level_next = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Merges APB writes and FIFO-buffered accelerator writes onto the bank's write port.
// Optional grant statistics ports are enabled by defining REG_WR_ARB_STATS_EN.
module reg_wr_arbiter
  import reg_wr_arbiter_pkg::*;
#(
  parameter int REG_NUM        = 8,
  parameter int REG_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 4,
  localparam int AW = reg_aw(REG_NUM),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      apb_wr_valid,
  output logic                      apb_wr_ready,
  input  logic [AW-1:0]             apb_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] apb_wr_data,
  input  logic                      acc_wr_valid,
  output logic                      acc_wr_ready,
  input  logic [AW-1:0]             acc_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] acc_wr_data,
  output logic                      reg_wen,
  output logic [AW-1:0]             reg_waddr,
  output logic [REG_DATA_WIDTH-1:0] reg_wdata,
  output logic [LW-1:0]             fifo_level
`ifdef REG_WR_ARB_STATS_EN
  ,
  output logic [15:0]               apb_grant_cnt,
  output logic [15:0]               acc_grant_cnt,
  output logic                      starve_hit
`endif
);

  localparam int EW = AW + REG_DATA_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          forced;
  gnt_e          gnt;
  logic [SW-1:0] starve_cnt;

  assign acc_wr_ready = ~full & ~reset;
  assign push         = acc_wr_valid & acc_wr_ready;
  assign forced       = ~empty & (starve_cnt == STARVE_MAX);

  always_comb begin
    gnt = GNT_NONE;
    if (reset)             gnt = GNT_NONE;
    else if (forced)       gnt = GNT_ACC;
    else if (apb_wr_valid) gnt = GNT_APB;
    else if (!empty)       gnt = GNT_ACC;
  end

  assign apb_wr_ready = (gnt == GNT_APB);
  assign pop          = (gnt == GNT_ACC);

  reg_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({acc_wr_addr, acc_wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // The starve count only measures APB wins while an accelerator entry is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      reg_wen    <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
    end else begin
      reg_wen <= (gnt != GNT_NONE);
      if (gnt == GNT_APB)      {reg_waddr, reg_wdata} <= {apb_wr_addr, apb_wr_data};
      else if (gnt == GNT_ACC) {reg_waddr, reg_wdata} <= head;

      if (empty || gnt == GNT_ACC)
        starve_cnt <= '0;
      else if (gnt == GNT_APB && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef REG_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      apb_grant_cnt <= '0;
      acc_grant_cnt <= '0;
      starve_hit    <= 1'b0;
    end else begin
      if (gnt == GNT_APB) apb_grant_cnt <= apb_grant_cnt + 16'd1;
      if (gnt == GNT_ACC) acc_grant_cnt <= acc_grant_cnt + 16'd1;
      starve_hit <= forced;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed vector table, reset
// sequences and a randomized run against a queue-based reference model.
module tb_reg_wr_arbiter;
  import reg_wr_arbiter_pkg::*;

  localparam int DEPTH  = 4;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        apb_wr_valid;
  logic        apb_wr_ready;
  logic [2:0]  apb_wr_addr;
  logic [31:0] apb_wr_data;
  logic        acc_wr_valid;
  logic        acc_wr_ready;
  logic [2:0]  acc_wr_addr;
  logic [31:0] acc_wr_data;
  logic        reg_wen;
  logic [2:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [2:0]  fifo_level;
`ifdef REG_WR_ARB_STATS_EN
  logic [15:0] apb_grant_cnt;
  logic [15:0] acc_grant_cnt;
  logic        starve_hit;
`endif

  always #5 clk = ~clk;

  reg_wr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .apb_wr_valid (apb_wr_valid),
    .apb_wr_ready (apb_wr_ready),
    .apb_wr_addr  (apb_wr_addr),
    .apb_wr_data  (apb_wr_data),
    .acc_wr_valid (acc_wr_valid),
    .acc_wr_ready (acc_wr_ready),
    .acc_wr_addr  (acc_wr_addr),
    .acc_wr_data  (acc_wr_data),
    .reg_wen      (reg_wen),
    .reg_waddr    (reg_waddr),
    .reg_wdata    (reg_wdata),
    .fifo_level   (fifo_level)
`ifdef REG_WR_ARB_STATS_EN
    ,
    .apb_grant_cnt(apb_grant_cnt),
    .acc_grant_cnt(acc_grant_cnt),
    .starve_hit   (starve_hit)
`endif
  );

  // Inputs for one cycle, readies expected in that cycle, and bank-port
  // values expected from the previous edge.
  typedef struct {
    logic        av;
    logic [2:0]  aa;
    logic [31:0] ad;
    logic        cv;
    logic [2:0]  ca;
    logic [31:0] cd;
    logic        e_ardy;
    logic        e_crdy;
    logic        e_wen;
    logic [2:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [2:0]  e_lvl;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input vec_t v, input string nm);
    vectors++;
    if (apb_wr_ready !== v.e_ardy || acc_wr_ready !== v.e_crdy || reg_wen !== v.e_wen ||
        reg_waddr !== v.e_waddr || reg_wdata !== v.e_wdata || fifo_level !== v.e_lvl) begin
      miscompares++;
      $display("FAIL %s: got ardy=%0b crdy=%0b wen=%0b waddr=%0d wdata=%h lvl=%0d, want ardy=%0b crdy=%0b wen=%0b waddr=%0d wdata=%h lvl=%0d",
               nm, apb_wr_ready, acc_wr_ready, reg_wen, reg_waddr, reg_wdata, fifo_level,
               v.e_ardy, v.e_crdy, v.e_wen, v.e_waddr, v.e_wdata, v.e_lvl);
    end else begin
      $display("ok   %s: ardy=%0b crdy=%0b wen=%0b waddr=%0d wdata=%h lvl=%0d",
               nm, apb_wr_ready, acc_wr_ready, reg_wen, reg_waddr, reg_wdata, fifo_level);
    end
  endtask

  task automatic drive(input vec_t v);
    apb_wr_valid = v.av;
    apb_wr_addr  = v.aa;
    apb_wr_data  = v.ad;
    acc_wr_valid = v.cv;
    acc_wr_addr  = v.ca;
    acc_wr_data  = v.cd;
  endtask

  task automatic step(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(v, nm);
  endtask

  vec_t tbl [31];
  vec_t idle;

  // Reference model state
  wr_entry_t   q [$];
  int          starve;
  logic        m_wen;
  logic [2:0]  m_waddr;
  logic [31:0] m_wdata;

  initial begin
    tbl[0]  = '{0,0,0,            0,0,0,            0,1,0,0,0,0};
    tbl[1]  = '{1,3,32'hDEADBEEF, 0,0,0,            1,1,0,0,0,0};
    tbl[2]  = '{0,0,0,            0,0,0,            0,1,1,3,32'hDEADBEEF,0};
    tbl[3]  = '{0,0,0,            1,1,32'h11,       0,1,0,3,32'hDEADBEEF,0};
    tbl[4]  = '{0,0,0,            1,2,32'h22,       0,1,0,3,32'hDEADBEEF,1};
    tbl[5]  = '{0,0,0,            1,3,32'h33,       0,1,1,1,32'h11,1};
    tbl[6]  = '{0,0,0,            0,0,0,            0,1,1,2,32'h22,1};
    tbl[7]  = '{0,0,0,            0,0,0,            0,1,1,3,32'h33,0};
    tbl[8]  = '{0,0,0,            0,0,0,            0,1,0,3,32'h33,0};
    tbl[9]  = '{1,7,32'h70,       1,5,32'h55,       1,1,0,3,32'h33,0};
    tbl[10] = '{1,7,32'h71,       0,0,0,            1,1,1,7,32'h70,1};
    tbl[11] = '{1,7,32'h72,       0,0,0,            1,1,1,7,32'h71,1};
    tbl[12] = '{1,7,32'h73,       0,0,0,            1,1,1,7,32'h72,1};
    tbl[13] = '{1,7,32'h74,       0,0,0,            1,1,1,7,32'h73,1};
    tbl[14] = '{1,7,32'h75,       0,0,0,            0,1,1,7,32'h74,1};
    tbl[15] = '{1,7,32'h75,       0,0,0,            1,1,1,5,32'h55,0};
    tbl[16] = '{0,0,0,            0,0,0,            0,1,1,7,32'h75,0};
    tbl[17] = '{0,0,0,            0,0,0,            0,1,0,7,32'h75,0};
    tbl[18] = '{1,2,32'hA0,       1,1,32'h101,      1,1,0,7,32'h75,0};
    tbl[19] = '{1,2,32'hA1,       1,2,32'h102,      1,1,1,2,32'hA0,1};
    tbl[20] = '{1,2,32'hA2,       1,3,32'h103,      1,1,1,2,32'hA1,2};
    tbl[21] = '{1,2,32'hA3,       1,4,32'h104,      1,1,1,2,32'hA2,3};
    tbl[22] = '{1,2,32'hA4,       1,5,32'h105,      1,0,1,2,32'hA3,4};
    tbl[23] = '{1,2,32'hA5,       1,5,32'h105,      0,0,1,2,32'hA4,4};
    tbl[24] = '{1,2,32'hA5,       1,5,32'h105,      1,1,1,1,32'h101,3};
    tbl[25] = '{0,0,0,            0,0,0,            0,0,1,2,32'hA5,4};
    tbl[26] = '{0,0,0,            0,0,0,            0,1,1,2,32'h102,3};
    tbl[27] = '{0,0,0,            0,0,0,            0,1,1,3,32'h103,2};
    tbl[28] = '{0,0,0,            0,0,0,            0,1,1,4,32'h104,1};
    tbl[29] = '{0,0,0,            0,0,0,            0,1,1,5,32'h105,0};
    tbl[30] = '{0,0,0,            0,0,0,            0,1,0,5,32'h105,0};
    idle    = '{0,0,0,            0,0,0,            0,1,0,0,0,0};

    // Readies must be forced low while reset is held, even with requests up.
    reset = 1'b1;
    drive('{1,0,0, 1,0,0, 0,0,0,0,0,0});
    @(negedge clk);
    check('{1,0,0, 1,0,0, 0,0,0,0,0,0}, "reset_hold");
    drive(idle);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Reset with three entries queued and a bank write in flight.
    step('{1,1,32'hB0, 1,6,32'h66, 1,1,0,5,32'h105,0}, "rst_fill0");
    step('{1,1,32'hB1, 1,6,32'h67, 1,1,1,1,32'hB0,1},  "rst_fill1");
    step('{1,1,32'hB2, 1,6,32'h68, 1,1,1,1,32'hB1,2},  "rst_fill2");
    step('{1,1,32'hB3, 0,0,0,      1,1,1,1,32'hB2,3},  "rst_fill3");
    #1 reset = 1'b1;
    #1 check('{1,1,32'hB3, 0,0,0, 0,0,0,0,0,0}, "reset_mid");
    drive(idle);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(idle, $sformatf("post_rst_idle%0d", i));
    step('{1,4,32'hC0FFEE, 0,0,0, 1,1,0,0,0,0},          "post_rst_apb");
    step('{0,0,0,          0,0,0, 0,1,1,4,32'hC0FFEE,0}, "post_rst_wr");

    // Randomized run against the queue model.
    starve  = 0;
    m_wen   = 1'b0;
    m_waddr = 3'd4;
    m_wdata = 32'hC0FFEE;
    begin
      logic        cur_av = 1'b0;
      logic [2:0]  cur_aa = '0;
      logic [31:0] cur_ad = '0;
      logic        hold = 1'b0;
      for (int n = 0; n < 400; n++) begin
        vec_t      v;
        logic      cv;
        logic [2:0] ca;
        logic [31:0] cd;
        logic      f;
        logic      frc;
        logic      room;
        wr_entry_t e;
        if (!hold) begin
          cur_av = ($urandom_range(0, 9) < 6);
          cur_aa = 3'($urandom_range(0, 7));
          cur_ad = $urandom();
        end
        cv   = ($urandom_range(0, 9) < 5);
        ca   = 3'($urandom_range(0, 7));
        cd   = $urandom();
        f    = (q.size() != 0);
        frc  = f && (starve == STARVE);
        room = (q.size() < DEPTH);
        v = '{cur_av, cur_aa, cur_ad, cv, ca, cd,
              cur_av && !frc, room, m_wen, m_waddr, m_wdata, 3'(q.size())};
        step(v, $sformatf("rand%0d", n));

        if (frc || (!cur_av && f)) begin
          e = q.pop_front();
          m_wen = 1'b1; m_waddr = e.addr; m_wdata = e.data;
          starve = 0;
        end else if (cur_av) begin
          m_wen = 1'b1; m_waddr = cur_aa; m_wdata = cur_ad;
          if (f && starve < STARVE) starve++;
        end else begin
          m_wen = 1'b0;
        end
        if (!f) starve = 0;
        if (cv && room) begin
          e.addr = ca;
          e.data = cd;
          q.push_back(e);
        end
        hold = cur_av && frc;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Write arbiter and scheduler for the APB-visible register bank. It merges two write sources into the bank's single write port:
- the APB slave write path;
- the accelerator write path, which is buffered in a small FIFO.

APB writes normally have priority. A starvation limit guarantees the accelerator a slot. The block sits between the APB slave/accelerator and the register bank, and drives the bank's write-enable, address and data.

## Interface
Parameters:
- REG_NUM, 8: number of registers in the bank; AW = $clog2(max(REG_NUM,2)).
- REG_DATA_WIDTH, 32: register data width.
- FIFO_DEPTH, 4: accelerator write FIFO depth; power of two, ≥2.
- STARVE_LIMIT, 4: maximum consecutive APB grants while the FIFO is non-empty; must be ≥1.

Ports:
- clk  in  1  single clock; everything is on posedge.
- reset  in  1  asynchronous, active-high reset.
- apb_wr_valid  in  1  APB write request.
- apb_wr_ready  out  1  APB write accepted this cycle (combinational grant).
- apb_wr_addr  in  AW  APB register index.
- apb_wr_data  in  REG_DATA_WIDTH  APB write data.
- acc_wr_valid  in  1  accelerator write request.
- acc_wr_ready  out  1  FIFO can accept; equals !full.
- acc_wr_addr  in  AW  accelerator register index.
- acc_wr_data  in  REG_DATA_WIDTH  accelerator write data.
- reg_wen  out  1  registered write enable to the bank.
- reg_waddr  out  AW  registered write index.
- reg_wdata  out  REG_DATA_WIDTH  registered write data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset asserted:
  - FIFO empties; starve_cnt clears to 0.
  - reg_wen, reg_waddr, reg_wdata and fifo_level are 0.
  - apb_wr_ready and acc_wr_ready are forced to 0.
- Accelerator push: when acc_wr_valid && acc_wr_ready, {addr,data} is written at the tail.
  - A push while full is impossible, because ready is low.
  - There is no bypass: an entry becomes eligible the cycle after it is pushed.
- Candidates each cycle: A = apb_wr_valid; F = FIFO non-empty.
- Grant rule:
  - F && starve_cnt == STARVE_LIMIT → FIFO head.
  - Else if A → APB.
  - Else if F → FIFO head.
  - Else no grant.
- starve_cnt update:
  - Increments on an APB grant while F, saturating at STARVE_LIMIT.
  - Clears on any FIFO grant, and whenever F == 0.
- APB grant: apb_wr_ready = 1 in the same cycle. An ungranted APB request must hold valid, addr and data stable.
- FIFO grant: the head pops at the clock edge.
- Simultaneous push and pop: both take effect, so the level is unchanged. When full, the pop frees a slot only from the next cycle, because acc_wr_ready is computed from the registered full flag.
- Output stage: the granted addr/data is registered into reg_waddr/reg_wdata with reg_wen = 1 for exactly one cycle. When there is no grant, reg_wen = 0 and reg_waddr/reg_wdata hold their values.
- Index range: indices ≥ REG_NUM are forwarded unchanged; the bank ignores them.
- Ordering:
  - Accelerator writes retire in push order.
  - APB writes retire in acceptance order.
  - There is no cross-source ordering guarantee.

## Timing
- APB: request in cycle N with the grant → reg_wen in cycle N+1 (1-cycle latency).
- Accelerator: push at edge N (no contention) → eligible in cycle N+1 → reg_wen in cycle N+2.
- Throughput: one bank write per cycle total.
- Worst-case accelerator wait under continuous APB traffic: STARVE_LIMIT cycles per entry.
- Reset mid-operation: in-flight FIFO contents are discarded and any reg_wen pulse is cancelled asynchronously.

## Configuration
- REG_WR_ARB_STATS_EN defined:
  - Adds outputs apb_grant_cnt and acc_grant_cnt, 16 bits each. Each increments on its grant and wraps at 0xFFFF→0.
  - Adds output starve_hit (1 bit). It pulses 1 cycle after any grant forced by the starvation rule.
  - All three reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package holds:
  - the AW derivation function (clog2 with minimum 2);
  - the write-entry struct {addr, data};
  - the grant encoding constants GNT_NONE, GNT_APB, GNT_ACC.
- One sub-module: reg_wr_fifo, a synchronous FIFO parameterised by depth and entry width, with full/empty/level.
- The arbiter, starve counter and output register are in the top.

## Test plan
- APB only: write addr 3, data 0xDEADBEEF in cycle 5 → reg_wen=1, reg_waddr=3, reg_wdata=0xDEADBEEF in cycle 6; apb_wr_ready=1 in cycle 5.
- Accelerator only: push addr 1/0x11, 2/0x22, 3/0x33 back-to-back from cycle 10 → bank writes in cycles 12, 13, 14, in order; fifo_level peaks at 1.
- FIFO full: 5 pushes with APB held valid and STARVE_LIMIT=4 → acc_wr_ready=0 after the 4th push (fifo_level=4); the 5th push waits until the starvation grant pops the head.
- Starvation: APB continuously valid, one FIFO entry present → APB wins 4 cycles, FIFO wins the 5th, APB resumes; starve_cnt returns to 0.
- Simultaneous: APB request and FIFO non-empty with starve_cnt=0 → APB granted; the FIFO entry retires the next cycle once APB deasserts.
- Reset mid-stream: assert reset with 3 entries queued and reg_wen=1 → reg_wen=0 immediately, fifo_level=0, and no writes after release until new requests arrive.
